// File: rtl/exec_stage_ctrl_pkg.sv
// Shared CPU definitions for the execute-stage controller: FSM states,
// opcode field layout and the default multi-cycle occupancy.
package exec_stage_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } exec_state_e;

    localparam int OP_MULTI_BIT      = 4;
    localparam int MC_CYCLES_DEFAULT = 4;
    localparam int REG_IDX_W         = 3;

    function automatic logic is_multi_op(input logic [4:0] opcode);
        return opcode[OP_MULTI_BIT];
    endfunction

endpackage

// File: rtl/exec_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// write-back or when a flushed writer is killed; write-back bypasses the hazard.
module exec_scoreboard
    import exec_stage_ctrl_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] chk_src1,
    input  logic [REG_IDX_W-1:0] chk_src2,
    input  logic [REG_IDX_W-1:0] chk_dst,
    input  logic                 chk_writes,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic                 kill_en,
    input  logic [REG_IDX_W-1:0] kill_idx,
    output logic                 hazard
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] kill_mask;
    logic [NREGS-1:0] need_mask;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
        assign set_mask[gi]  = set_en  && (set_idx  == REG_IDX_W'(gi));
        assign clr_mask[gi]  = clr_en  && (clr_idx  == REG_IDX_W'(gi));
        assign kill_mask[gi] = kill_en && (kill_idx == REG_IDX_W'(gi));
        assign need_mask[gi] = (chk_src1 == REG_IDX_W'(gi)) ||
                               (chk_src2 == REG_IDX_W'(gi)) ||
                               (chk_writes && (chk_dst == REG_IDX_W'(gi)));
    end

    // A register retiring this very cycle no longer blocks the reader.
    assign hazard = |(pending_q & ~clr_mask & need_mask);

    always_comb begin
        pending_d = (pending_q & ~clr_mask & ~kill_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/exec_stage_ctrl.sv
// Execute-stage issue controller: hazard-gated issue from decode, a RUN/MULTI
// FSM that freezes the execute register for multi-cycle vector ops, and flush.
module exec_stage_ctrl
    import exec_stage_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = MC_CYCLES_DEFAULT,  // legal 2..15
    parameter int NREGS     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [4:0]           id_opcode,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic [REG_IDX_W-1:0] id_dst,
    input  logic                 id_writes,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_reg,
    input  logic                 flush,
    output logic                 ex_en,
    output logic                 ex_valid,
    output logic                 id_ready,
    output logic                 stall,
    output logic                 busy
);

    localparam logic [3:0] CNT_LOAD = 4'(MC_CYCLES - 1);

    exec_state_e          state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 ex_valid_q, ex_valid_d;
    logic [REG_IDX_W-1:0] ex_dst_q, ex_dst_d;
    logic                 ex_writes_q, ex_writes_d;
    logic                 hazard;
    logic                 issue;
    logic                 unused_opcode_bits;

    assign unused_opcode_bits = ^id_opcode[3:0];

    exec_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .chk_src1   (id_src1),
        .chk_src2   (id_src2),
        .chk_dst    (id_dst),
        .chk_writes (id_writes),
        .set_en     (issue && id_writes),
        .set_idx    (id_dst),
        .clr_en     (wb_valid),
        .clr_idx    (wb_reg),
        .kill_en    (flush && ex_valid_q && ex_writes_q),
        .kill_idx   (ex_dst_q),
        .hazard     (hazard)
    );

    assign issue    = id_valid && !hazard && (state_q == ST_RUN) && !flush;
    assign id_ready = issue;
    assign stall    = id_valid && !issue;
    assign ex_en    = (state_q == ST_RUN);
    assign busy     = (state_q == ST_MULTI);
    assign ex_valid = ex_valid_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ex_valid_d  = ex_valid_q;
        ex_dst_d    = ex_dst_q;
        ex_writes_d = ex_writes_q;
        if (flush) begin
            state_d     = ST_RUN;
            cnt_d       = '0;
            ex_valid_d  = 1'b0;
            ex_writes_d = 1'b0;
        end else if (state_q == ST_MULTI) begin
            // The final occupancy cycle is the first RUN cycle, hence exit at 1.
            if (cnt_q <= 4'd1) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else begin
            ex_valid_d  = issue;
            ex_writes_d = issue && id_writes;
            if (issue) begin
                ex_dst_d = id_dst;
                if (is_multi_op(id_opcode)) begin
                    state_d = ST_MULTI;
                    cnt_d   = CNT_LOAD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            ex_valid_q  <= 1'b0;
            ex_dst_q    <= '0;
            ex_writes_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_valid_q  <= ex_valid_d;
            ex_dst_q    <= ex_dst_d;
            ex_writes_q <= ex_writes_d;
        end
    end

endmodule

// File: tb/tb_exec_stage_ctrl.sv
// Bench for exec_stage_ctrl: directed sequences with literal expectations plus
// a per-cycle comparison against a behavioural occupancy/scoreboard model.
module tb_exec_stage_ctrl;

    localparam int MC = 4;
    localparam int NR = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_opcode = '0;
    logic [2:0] id_src1 = '0;
    logic [2:0] id_src2 = '0;
    logic [2:0] id_dst = '0;
    logic       id_writes = 1'b0;
    logic       wb_valid = 1'b0;
    logic [2:0] wb_reg = '0;
    logic       flush = 1'b0;
    logic       ex_en, ex_valid, id_ready, stall, busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    exec_stage_ctrl #(.MC_CYCLES(MC), .NREGS(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_opcode (id_opcode),
        .id_src1   (id_src1),
        .id_src2   (id_src2),
        .id_dst    (id_dst),
        .id_writes (id_writes),
        .wb_valid  (wb_valid),
        .wb_reg    (wb_reg),
        .flush     (flush),
        .ex_en     (ex_en),
        .ex_valid  (ex_valid),
        .id_ready  (id_ready),
        .stall     (stall),
        .busy      (busy)
    );

    wire [NR-1:0] pend_act = dut.u_sb.pending_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: registers awaiting write-back, cycles the execute stage remains
    // frozen, and the instruction currently held in execute.
    bit [NR-1:0] m_pend      = '0;
    int          m_busy_left = 0;
    bit          m_exv       = 1'b0;
    bit          m_exw       = 1'b0;
    bit [2:0]    m_exd       = '0;

    function automatic bit m_issue();
        bit [NR-1:0] live;
        live = m_pend;
        if (wb_valid) live[wb_reg] = 1'b0;
        return id_valid && !flush && (m_busy_left == 0) &&
               !(live[id_src1] || live[id_src2] || (id_writes && live[id_dst]));
    endfunction

    function automatic bit [NR-1:0] m_next_pend();
        bit [NR-1:0] np;
        np = m_pend;
        if (wb_valid) np[wb_reg] = 1'b0;
        if (flush && m_exv && m_exw) np[m_exd] = 1'b0;
        if (m_issue() && id_writes) np[id_dst] = 1'b1;
        return np;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend      <= '0;
            m_busy_left <= 0;
            m_exv       <= 1'b0;
            m_exw       <= 1'b0;
            m_exd       <= '0;
        end else begin
            m_pend <= m_next_pend();
            if (flush) m_busy_left <= 0;
            else if (m_busy_left > 0) m_busy_left <= m_busy_left - 1;
            else if (m_issue() && id_opcode[4]) m_busy_left <= MC - 1;
            if (flush) m_exv <= 1'b0;
            else if (m_busy_left == 0) m_exv <= m_issue();
            if (m_issue()) begin
                m_exd <= id_dst;
                m_exw <= id_writes;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_ex_en",    ex_en,    m_busy_left == 0);
            check("cyc_busy",     busy,     m_busy_left > 0);
            check("cyc_ex_valid", ex_valid, m_exv);
            check("cyc_id_ready", id_ready, m_issue());
            check("cyc_stall",    stall,    id_valid && !m_issue());
            check("cyc_pending",  pend_act, m_pend);
        end
    end

    task automatic drv(input bit v, input logic [4:0] op, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [2:0] d, input bit w, input bit wbv, input logic [2:0] wbr,
                       input bit fl);
        id_valid  = v;
        id_opcode = op;
        id_src1   = s1;
        id_src2   = s2;
        id_dst    = d;
        id_writes = w;
        wb_valid  = wbv;
        wb_reg    = wbr;
        flush     = fl;
        $display("txn t=%0t v=%0b op=%02h s1=%0d s2=%0d d=%0d w=%0b wb=%0b/%0d flush=%0b",
                 $time, v, op, s1, s2, d, w, wbv, wbr, fl);
    endtask

    task automatic idle();
        drv(0, 5'h00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_ex_valid", ex_valid, 1'b0);
        check("rst_pending", pend_act, 8'h00);
        check("rst_ex_en", ex_en, 1'b1);
        next();
        next();
        rst_n = 1'b1;

        // Plain single-cycle issue writing r3
        drv(1, 5'h02, 0, 0, 3, 1, 0, 0, 0);
        #1 check("issue_ready", id_ready, 1'b1);
        next();
        // RAW on r3 stalls, then write-back bypass lets it issue
        drv(1, 5'h02, 3, 0, 0, 0, 0, 0, 0);
        check("issue_ex_valid", ex_valid, 1'b1);
        check("issue_pend3", pend_act[3], 1'b1);
        #1 check("raw_stall", stall, 1'b1);
        check("raw_ready", id_ready, 1'b0);
        next();
        check("raw_bubble", ex_valid, 1'b0);
        drv(1, 5'h02, 3, 0, 0, 0, 1, 3, 0);
        #1 check("bypass_ready", id_ready, 1'b1);
        check("bypass_stall", stall, 1'b0);
        next();
        check("bypass_ex_valid", ex_valid, 1'b1);
        check("bypass_pend3", pend_act[3], 1'b0);

        // Multi-cycle op occupies execute for MC cycles
        drv(1, 5'h11, 0, 0, 0, 0, 0, 0, 0);
        #1 check("multi_ready", id_ready, 1'b1);
        next();
        drv(1, 5'h02, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < MC - 1; k++) begin
            #1;
            check("multi_busy", busy, 1'b1);
            check("multi_ex_en", ex_en, 1'b0);
            check("multi_ready_lo", id_ready, 1'b0);
            next();
        end
        #1;
        check("multi_done_busy", busy, 1'b0);
        check("multi_done_ex_en", ex_en, 1'b1);
        check("multi_done_ready", id_ready, 1'b1);
        next();
        idle();
        next();

        // Flush in the second MULTI cycle of an op writing r5
        drv(1, 5'h11, 0, 0, 5, 1, 0, 0, 0);
        next();
        idle();
        #1 check("flush_pend5_set", pend_act[5], 1'b1);
        next();
        drv(0, 5'h00, 0, 0, 0, 0, 0, 0, 1);
        #1 check("flush_cycle_busy", busy, 1'b1);
        next();
        idle();
        check("flush_busy", busy, 1'b0);
        check("flush_ex_valid", ex_valid, 1'b0);
        check("flush_pend5", pend_act[5], 1'b0);

        // Same-edge set and clear of r2 leaves it set
        drv(1, 5'h02, 0, 0, 2, 1, 1, 2, 0);
        #1 check("same_edge_ready", id_ready, 1'b1);
        next();
        check("same_edge_pend2", pend_act[2], 1'b1);
        drv(0, 5'h00, 0, 0, 0, 0, 1, 2, 0);
        next();
        check("clear_pend2", pend_act[2], 1'b0);

        // Hazards on src2 and on the destination (only when writing)
        drv(1, 5'h03, 0, 0, 7, 1, 0, 0, 0);
        next();
        drv(1, 5'h03, 1, 7, 0, 0, 0, 0, 0);
        #1 check("src2_stall", stall, 1'b1);
        drv(1, 5'h03, 0, 0, 7, 0, 0, 0, 0);
        #1 check("dst_nowrite_ready", id_ready, 1'b1);
        next();
        drv(1, 5'h03, 0, 0, 7, 1, 0, 0, 0);
        #1 check("waw_stall", stall, 1'b1);
        drv(0, 5'h00, 0, 0, 0, 0, 1, 6, 0);
        next();
        check("wb_nonpending", pend_act, 8'h80);
        drv(0, 5'h00, 0, 0, 0, 0, 1, 7, 0);
        next();

        // Flush with an empty execute stage leaves the scoreboard alone
        drv(1, 5'h04, 0, 0, 4, 1, 0, 0, 0);
        next();
        idle();
        next();
        drv(0, 5'h00, 0, 0, 0, 0, 0, 0, 1);
        next();
        idle();
        check("flush_empty_pend4", pend_act[4], 1'b1);
        check("flush_empty_ex_valid", ex_valid, 1'b0);
        drv(0, 5'h00, 0, 0, 0, 0, 1, 4, 0);
        next();

        // Asynchronous reset in the middle of a multi-cycle op
        drv(1, 5'h11, 0, 0, 1, 1, 0, 0, 0);
        next();
        drv(1, 5'h02, 0, 0, 0, 0, 0, 0, 0);
        next();
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_ex_valid", ex_valid, 1'b0);
        check("arst_pending", pend_act, 8'h00);
        next();
        next();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", id_ready, 1'b1);
        check("post_rst_ex_en", ex_en, 1'b1);
        next();
        check("post_rst_ex_valid", ex_valid, 1'b1);
        idle();
        next();
        next();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
